// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial memory controller: memory command
// encodings, access-size codes, FSM state codes and a size helper.
package mem_ctrl_pkg;

   // mem_vis_signal command encodings
   localparam logic [1:0] IDLE      = 2'b00;
   localparam logic [1:0] READ_INST = 2'b01;
   localparam logic [1:0] READ_DATA = 2'b10;
   localparam logic [1:0] WRITE     = 2'b11;

   // data_size codes (11 behaves as a word)
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // Byte counter width: at most four bytes per transaction
   localparam int unsigned CNT_W = 2;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INST_RD = 3'd1,
      S_DATA_RD = 3'd2,
      S_DATA_WR = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   // Number of bytes moved for a given data_size code
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 3'd1;
         SIZE_HALF: return 3'd2;
         SIZE_WORD: return 3'd4;
         default:   return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_arbiter.sv
// Grant logic between instruction fetch and load/store requesters.
// MEM_CTRL_RR_EN: round-robin via a last-grant bit; otherwise data has
// fixed priority over instruction fetch.
module mem_arbiter (
`ifdef MEM_CTRL_RR_EN
   input  logic clk,
   input  logic rst,
`endif
   input  logic grant_en,
   input  logic inst_req,
   input  logic data_req,
   output logic grant_inst_c,
   output logic grant_data_c
);

   logic pick_data_c;

`ifdef MEM_CTRL_RR_EN
   logic last_data_q;

   // Data wins unless it was also the last one served and inst is waiting
   assign pick_data_c = data_req & (~inst_req | ~last_data_q);

   // Remember who was granted last; reset treats instruction as last served
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_data_q <= 1'b0;
      end else if (grant_inst_c | grant_data_c) begin
         last_data_q <= grant_data_c;
      end
   end
`else
   assign pick_data_c = data_req;
`endif

   assign grant_data_c = grant_en & pick_data_c;
   assign grant_inst_c = grant_en & inst_req & ~pick_data_c;

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serves instruction fetches and data
// loads/stores one byte per cycle over an 8-bit memory port.
// MEM_CTRL_RR_EN selects round-robin arbitration (default: data priority).
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 17,
   parameter int unsigned LEN        = 32,
   parameter int unsigned BYTE_SIZE  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inst_req,
   input  logic [ADDR_WIDTH-1:0] inst_addr,
   output logic                  inst_ready,
   output logic [LEN-1:0]        inst_data,
   input  logic                  data_req,
   input  logic                  data_we,
   input  logic [1:0]            data_size,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [LEN-1:0]        data_wdata,
   output logic                  data_ready,
   output logic [LEN-1:0]        data_rdata,
   output logic [ADDR_WIDTH-1:0] mem_vis_addr,
   output logic [1:0]            mem_vis_signal,
   output logic [BYTE_SIZE-1:0]  writen_data,
   input  logic [BYTE_SIZE-1:0]  mem_data
);

   state_t               state_q, state_n;
   logic [CNT_W-1:0]     k_q, k_n, k_inc;
   logic [2:0]           n_q, n_n;
   logic                 owner_data_q, owner_data_n;
   logic [LEN-1:0]       wdata_q, wdata_n;
   logic [LEN-1:0]       rbuf_q, rbuf_n;
   logic                 cap_valid_q, cap_valid_n;
   logic [CNT_W-1:0]     cap_idx_q, cap_idx_n;

   logic [ADDR_WIDTH-1:0] addr_n;
   logic [1:0]            sig_n;
   logic [BYTE_SIZE-1:0]  wr_n;
   logic                  inst_ready_n, data_ready_n;
   logic [LEN-1:0]        inst_data_n, data_rdata_n;

   logic arb_en_c, grant_inst_c, grant_data_c;

   assign arb_en_c = (state_q == S_IDLE);
   assign k_inc    = k_q + 2'd1;

   mem_arbiter u_arb (
`ifdef MEM_CTRL_RR_EN
      .clk          (clk),
      .rst          (rst),
`endif
      .grant_en     (arb_en_c),
      .inst_req     (inst_req),
      .data_req     (data_req),
      .grant_inst_c (grant_inst_c),
      .grant_data_c (grant_data_c)
   );

   // Next-state and next-output logic; every output is registered below
   always_comb begin
      state_n      = state_q;
      k_n          = k_q;
      n_n          = n_q;
      owner_data_n = owner_data_q;
      wdata_n      = wdata_q;
      rbuf_n       = rbuf_q;
      cap_valid_n  = 1'b0;
      cap_idx_n    = k_q;
      addr_n       = mem_vis_addr;
      sig_n        = IDLE;
      wr_n         = writen_data;
      inst_ready_n = 1'b0;
      data_ready_n = 1'b0;
      inst_data_n  = inst_data;
      data_rdata_n = data_rdata;

      // Read byte issued last cycle is on mem_data now
      if (cap_valid_q) begin
         rbuf_n = rbuf_q | (LEN'(mem_data) << (BYTE_SIZE * cap_idx_q));
      end

      case (state_q)
         S_IDLE: begin
            k_n = '0;
            if (grant_data_c) begin
               owner_data_n = 1'b1;
               n_n          = size_bytes(data_size);
               wdata_n      = data_wdata;
               rbuf_n       = '0;
               addr_n       = data_addr;
               if (data_we) begin
                  state_n = S_DATA_WR;
                  sig_n   = WRITE;
                  wr_n    = data_wdata[BYTE_SIZE-1:0];
               end else begin
                  state_n = S_DATA_RD;
                  sig_n   = READ_DATA;
               end
            end else if (grant_inst_c) begin
               owner_data_n = 1'b0;
               n_n          = 3'd4;
               rbuf_n       = '0;
               addr_n       = inst_addr;
               state_n      = S_INST_RD;
               sig_n        = READ_INST;
            end
         end

         S_INST_RD, S_DATA_RD: begin
            // Issue phase: a read is on the bus this cycle
            if (mem_vis_signal != IDLE) begin
               cap_valid_n = 1'b1;
               cap_idx_n   = k_q;
               if (3'(k_q) != n_q - 3'd1) begin
                  k_n    = k_inc;
                  addr_n = mem_vis_addr + ADDR_WIDTH'(1);
                  sig_n  = mem_vis_signal;
               end
            end
            // Last byte arrives: publish result and pulse the owner's ready
            if (cap_valid_q && (3'(cap_idx_q) == n_q - 3'd1)) begin
               state_n = S_DONE;
               if (owner_data_q) begin
                  data_ready_n = 1'b1;
                  data_rdata_n = rbuf_n;
               end else begin
                  inst_ready_n = 1'b1;
                  inst_data_n  = rbuf_n;
               end
            end
         end

         S_DATA_WR: begin
            if (3'(k_q) != n_q - 3'd1) begin
               k_n    = k_inc;
               addr_n = mem_vis_addr + ADDR_WIDTH'(1);
               sig_n  = WRITE;
               wr_n   = BYTE_SIZE'(wdata_q >> (BYTE_SIZE * k_inc));
            end else begin
               state_n      = S_DONE;
               data_ready_n = 1'b1;
            end
         end

         S_DONE: begin
            state_n = S_IDLE;
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         k_q            <= '0;
         n_q            <= 3'd0;
         owner_data_q   <= 1'b0;
         wdata_q        <= '0;
         rbuf_q         <= '0;
         cap_valid_q    <= 1'b0;
         cap_idx_q      <= '0;
         mem_vis_addr   <= '0;
         mem_vis_signal <= IDLE;
         writen_data    <= '0;
         inst_ready     <= 1'b0;
         data_ready     <= 1'b0;
         inst_data      <= '0;
         data_rdata     <= '0;
      end else begin
         state_q        <= state_n;
         k_q            <= k_n;
         n_q            <= n_n;
         owner_data_q   <= owner_data_n;
         wdata_q        <= wdata_n;
         rbuf_q         <= rbuf_n;
         cap_valid_q    <= cap_valid_n;
         cap_idx_q      <= cap_idx_n;
         mem_vis_addr   <= addr_n;
         mem_vis_signal <= sig_n;
         writen_data    <= wr_n;
         inst_ready     <= inst_ready_n;
         data_ready     <= data_ready_n;
         inst_data      <= inst_data_n;
         data_rdata     <= data_rdata_n;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a registered byte-memory model.
// Expected arbitration order follows MEM_CTRL_RR_EN.
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   logic        clk;
   logic        rst;
   logic        inst_req;
   logic [16:0] inst_addr;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic        data_req;
   logic        data_we;
   logic [1:0]  data_size;
   logic [16:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_ready;
   logic [31:0] data_rdata;
   logic [16:0] mem_vis_addr;
   logic [1:0]  mem_vis_signal;
   logic [7:0]  writen_data;
   logic [7:0]  mem_data;

   mem_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .inst_req       (inst_req),
      .inst_addr      (inst_addr),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .data_req       (data_req),
      .data_we        (data_we),
      .data_size      (data_size),
      .data_addr      (data_addr),
      .data_wdata     (data_wdata),
      .data_ready     (data_ready),
      .data_rdata     (data_rdata),
      .mem_vis_addr   (mem_vis_addr),
      .mem_vis_signal (mem_vis_signal),
      .writen_data    (writen_data),
      .mem_data       (mem_data)
   );

`ifdef MEM_CTRL_RR_EN
   localparam logic EXP_SECOND_DATA = 1'b0;
`else
   localparam logic EXP_SECOND_DATA = 1'b1;
`endif

   typedef struct packed {
      logic [1:0]  sig;
      logic [16:0] addr;
      logic [7:0]  wd;
   } ev_t;

   logic [7:0] mem [0:131071];
   ev_t        ev_q[$];
   int         cyc;
   int         n_checks;
   int         n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Registered memory: read data valid the cycle after a READ command
   always @(posedge clk) begin
      if (mem_vis_signal == READ_INST || mem_vis_signal == READ_DATA)
         mem_data <= mem[mem_vis_addr];
      else if (mem_vis_signal == WRITE)
         mem[mem_vis_addr] <= writen_data;
   end

   // Record every non-idle bus command mid-cycle
   always @(negedge clk) begin
      if (mem_vis_signal != IDLE)
         ev_q.push_back({mem_vis_signal, mem_vis_addr, writen_data});
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ev_at(input int i);
      if (i < ev_q.size()) return 32'(ev_q[i]);
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] ev_exp(input logic [1:0] s, input logic [16:0] a, input logic [7:0] w);
      ev_t e;
      e.sig  = s;
      e.addr = a;
      e.wd   = w;
      return 32'(e);
   endfunction

   task automatic do_inst(input logic [16:0] a, output logic [31:0] rd, output int lat);
      int t0;
      @(negedge clk);
      ev_q.delete();
      inst_addr = a;
      inst_req  = 1'b1;
      t0  = cyc;
      lat = -1;
      rd  = '0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (inst_ready) begin
            lat = cyc - t0;
            rd  = inst_data;
            break;
         end
      end
      inst_req = 1'b0;
      if (lat < 0) check_eq("inst_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_data(input logic we, input logic [1:0] sz, input logic [16:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat);
      int t0;
      @(negedge clk);
      ev_q.delete();
      data_we    = we;
      data_size  = sz;
      data_addr  = a;
      data_wdata = wd;
      data_req   = 1'b1;
      t0  = cyc;
      lat = -1;
      rd  = '0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (data_ready) begin
            lat = cyc - t0;
            rd  = data_rdata;
            break;
         end
      end
      data_req = 1'b0;
      if (lat < 0) check_eq("data_timeout", 32'd0, 32'd1);
   endtask

   // Raise both requests together, report who completed first, then drop both
   task automatic both_req(output logic data_won, output logic [31:0] rd, output int lat);
      int t0;
      @(negedge clk);
      ev_q.delete();
      inst_addr = 17'h00100;
      data_we   = 1'b0;
      data_size = SIZE_HALF;
      data_addr = 17'h00300;
      inst_req  = 1'b1;
      data_req  = 1'b1;
      t0       = cyc;
      lat      = -1;
      data_won = 1'b0;
      rd       = '0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (inst_ready || data_ready) begin
            lat      = cyc - t0;
            data_won = data_ready;
            rd       = data_ready ? data_rdata : inst_data;
            break;
         end
      end
      inst_req = 1'b0;
      data_req = 1'b0;
      if (lat < 0) check_eq("both_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] w;
      logic [16:0] a;
      logic        dw;
      int          lat;
      int          bad;
      int          t0;

      n_checks   = 0;
      n_fail     = 0;
      cyc        = 0;
      mem_data   = 8'h00;
      inst_req   = 1'b0;
      inst_addr  = '0;
      data_req   = 1'b0;
      data_we    = 1'b0;
      data_size  = SIZE_BYTE;
      data_addr  = '0;
      data_wdata = '0;
      for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
      mem[17'h00100] = 8'h13; mem[17'h00101] = 8'h05;
      mem[17'h00102] = 8'h00; mem[17'h00103] = 8'h00;
      mem[17'h00300] = 8'h34; mem[17'h00301] = 8'h80;
      mem[17'h1FFFE] = 8'h11; mem[17'h1FFFF] = 8'h22;
      mem[17'h00000] = 8'h33; mem[17'h00001] = 8'h44;

      rst = 1'b0;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_sig",        32'(mem_vis_signal), 32'(IDLE));
      check_eq("rst_addr",       32'(mem_vis_addr),   32'd0);
      check_eq("rst_wdata",      32'(writen_data),    32'd0);
      check_eq("rst_readies",    32'({inst_ready, data_ready}), 32'd0);
      check_eq("rst_inst_data",  inst_data,  32'd0);
      check_eq("rst_data_rdata", data_rdata, 32'd0);
      rst = 1'b0;

      // Instruction fetch at 0x100
      do_inst(17'h00100, rd, lat);
      check_eq("inst_lat",  32'(lat), 32'd6);
      check_eq("inst_data", rd, 32'h0000_0513);
      check_eq("inst_nev",  32'(ev_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         a = 17'h00100 + 17'(i);
         check_eq($sformatf("inst_ev%0d", i), ev_at(i) & 32'h07FF_FF00,
                  ev_exp(READ_INST, a, 8'h00) & 32'h07FF_FF00);
      end
      repeat (2) @(negedge clk);
      check_eq("inst_hold", inst_data, 32'h0000_0513);

      // Word store then byte load from the middle of it
      do_data(1'b1, SIZE_WORD, 17'h00200, 32'hDEAD_BEEF, rd, lat);
      check_eq("st_lat", 32'(lat), 32'd5);
      check_eq("st_nev", 32'(ev_q.size()), 32'd4);
      w = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         a = 17'h00200 + 17'(i);
         check_eq($sformatf("st_ev%0d", i), ev_at(i), ev_exp(WRITE, a, 8'(w >> (8 * i))));
      end
      do_data(1'b0, SIZE_BYTE, 17'h00201, 32'h0, rd, lat);
      check_eq("ldb_lat",  32'(lat), 32'd3);
      check_eq("ldb_data", rd, 32'h0000_00BE);
      check_eq("ldb_nev",  32'(ev_q.size()), 32'd1);

      // Halfword load
      do_data(1'b0, SIZE_HALF, 17'h00300, 32'h0, rd, lat);
      check_eq("ldh_lat",  32'(lat), 32'd4);
      check_eq("ldh_data", rd, 32'h0000_8034);

      // Word load wrapping past the top of the address space
      do_data(1'b0, SIZE_WORD, 17'h1FFFE, 32'h0, rd, lat);
      check_eq("wrap_lat",  32'(lat), 32'd6);
      check_eq("wrap_data", rd, 32'h4433_2211);
      for (int i = 0; i < 4; i++) begin
         a = 17'h1FFFE + 17'(i);
         check_eq($sformatf("wrap_ev%0d", i), ev_at(i) & 32'h07FF_FF00,
                  ev_exp(READ_DATA, a, 8'h00) & 32'h07FF_FF00);
      end
      check_eq("inst_hold2", inst_data, 32'h0000_0513);

      // Reset after the second store byte aborts the transaction
      @(negedge clk);
      ev_q.delete();
      data_we    = 1'b1;
      data_size  = SIZE_WORD;
      data_addr  = 17'h00400;
      data_wdata = 32'h1122_3344;
      data_req   = 1'b1;
      t0 = cyc;
      repeat (2) @(negedge clk);
      check_eq("abrt_pre_cyc", 32'(cyc - t0), 32'd2);
      check_eq("abrt_pre_sig", 32'(mem_vis_signal), 32'(WRITE));
      @(posedge clk);
      #1;
      rst      = 1'b1;
      data_req = 1'b0;
      #1;
      check_eq("abrt_sig", 32'(mem_vis_signal), 32'(IDLE));
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (mem_vis_signal == WRITE || data_ready || inst_ready) bad++;
      end
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (mem_vis_signal == WRITE || data_ready || inst_ready) bad++;
      end
      check_eq("abrt_quiet",   32'(bad), 32'd0);
      check_eq("abrt_nev",     32'(ev_q.size()), 32'd2);
      check_eq("abrt_mem401",  32'(mem[17'h00401]), 32'h33);
      check_eq("abrt_mem402",  32'(mem[17'h00402]), 32'h00);
      check_eq("abrt_rdata",   data_rdata, 32'd0);
      check_eq("abrt_idata",   inst_data,  32'd0);

      // Simultaneous requests, twice, starting from reset arbitration state
      both_req(dw, rd, lat);
      check_eq("arb1_winner", 32'(dw), 32'd1);
      check_eq("arb1_lat",    32'(lat), 32'd4);
      check_eq("arb1_data",   rd, 32'h0000_8034);
      both_req(dw, rd, lat);
      check_eq("arb2_winner", 32'(dw), 32'(EXP_SECOND_DATA));
      check_eq("arb2_lat",    32'(lat), EXP_SECOND_DATA ? 32'd4 : 32'd6);
      check_eq("arb2_data",   rd, EXP_SECOND_DATA ? 32'h0000_8034 : 32'h0000_0513);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 17, byte-address width of main memory.
REQ-002 SHALL have parameter LEN, default 32, requester data word width.
REQ-003 SHALL have parameter BYTE_SIZE, default 8, memory data width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port inst_req  input  1  instruction-fetch request, held until inst_ready.
REQ-007 SHALL have port inst_addr  input  ADDR_WIDTH  fetch byte address.
REQ-008 SHALL have port inst_ready  output  1  one-cycle completion pulse.
REQ-009 SHALL have port inst_data  output  LEN  fetched word, valid while inst_ready.
REQ-010 SHALL have port data_req  input  1  load/store request, held until data_ready.
REQ-011 SHALL have port data_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port data_size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-013 SHALL have port data_addr  input  ADDR_WIDTH  load/store byte address.
REQ-014 SHALL have port data_wdata  input  LEN  store data, low bytes used.
REQ-015 SHALL have port data_ready  output  1  one-cycle completion pulse.
REQ-016 SHALL have port data_rdata  output  LEN  load result, zero-extended, valid while data_ready.
REQ-017 SHALL have port mem_vis_addr  output  ADDR_WIDTH  byte address to main memory.
REQ-018 SHALL have port mem_vis_signal  output  2  IDLE/READ_INST/READ_DATA/WRITE command.
REQ-019 SHALL have port writen_data  output  BYTE_SIZE  byte to write.
REQ-020 SHALL have port mem_data  input  BYTE_SIZE  memory read byte, registered, valid the cycle after a READ command.

Function
REQ-021 SHALL implement FSM states IDLE, INST_RD, DATA_RD, DATA_WR, DONE.
REQ-022 SHALL, in IDLE, sample requests, latch address/size/wdata/requester, and clear byte counter k.
REQ-023 SHALL treat instruction fetches as n=4 bytes; data accesses as n=1/2/4 per data_size.
REQ-024 SHALL, when IDLE sees a request in cycle T, issue byte k in cycle T+1+k (k=0..n-1) with mem_vis_addr = (base+k) mod 2^ADDR_WIDTH.
REQ-025 SHALL drive mem_vis_signal READ_INST in INST_RD, READ_DATA in DATA_RD, WRITE in DATA_WR, and IDLE in IDLE and DONE.
REQ-026 SHALL drive writen_data = wdata[8k+7:8k] during store byte k.
REQ-027 SHALL capture mem_data into result byte k in cycle T+2+k (little-endian), with unfilled upper bytes zero.
REQ-028 SHALL enter DONE in cycle T+n+2 for reads and T+n+1 for writes, pulsing the owner's ready for exactly that cycle, then return to IDLE.
REQ-029 SHALL hold inst_data/data_rdata stable from DONE until the next capture into that register.
REQ-030 SHALL not preempt an in-flight transaction; a request dropped mid-transaction still completes, and its ready pulse is ignored by the requester.
REQ-031 SHALL not sample requests in DONE, leaving a minimum one IDLE cycle between transactions.
REQ-032 SHALL, with both requests in the same IDLE cycle, grant data (fixed priority) unless REQ-037 applies.

Reset
REQ-033 SHALL, on rst high at any time including mid-transaction, abort immediately to IDLE with mem_vis_signal=IDLE.
REQ-034 SHALL reset mem_vis_addr=0, writen_data=0, inst_ready=0, data_ready=0, inst_data=0, data_rdata=0, and k=0.
REQ-035 SHALL issue no WRITE in the cycle rst deasserts.

Configuration
REQ-036 SHALL, without MEM_CTRL_RR_EN, use fixed data-over-instruction priority.
REQ-037 SHALL, with MEM_CTRL_RR_EN defined, use round-robin priority via a last-grant bit (reset: instruction last), granting the requester not served last on simultaneous requests.

Structure
REQ-038 SHALL use shared-package constants IDLE, READ_INST, READ_DATA, and WRITE for mem_vis_signal encodings, plus size codes and FSM state codes.
REQ-039 SHALL place grant logic in one sub-module, mem_arbiter, containing the last-grant register under MEM_CTRL_RR_EN.

Verification
REQ-040 SHALL verify: inst_req with inst_addr=0x100 and bytes 13,05,00,00 -> READ_INST at 0x100..0x103, inst_ready with inst_data=0x00000513 in T+6.
REQ-041 SHALL verify: store word 0xDEADBEEF at 0x200, then load byte at 0x201 -> WRITE bytes EF,BE,AD,DE, then data_rdata=0x000000BE.
REQ-042 SHALL verify: simultaneous requests twice -> data granted both times without the macro; data then instruction with MEM_CTRL_RR_EN.
REQ-043 SHALL verify: word read at 0x1FFFE -> addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
REQ-044 SHALL verify: rst pulsed after the second store byte -> IDLE next edge, no further WRITE, no ready pulse.
REQ-045 SHALL verify: halfword load of 0x8034 -> data_rdata=0x00008034 with ready in T+4.
